// File: rtl/exec_ctrl.sv
// exec_ctrl: run / halt / single-step controller producing the core clock-enable.
// Breakpoint compare and the bp_hit flag exist only when EXEC_CTRL_BP_EN is defined.
module exec_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        cnt_clr,
    input  logic        phase,
    input  logic [11:0] pc,
    input  logic [11:0] bp_addr,
    input  logic        bp_valid,
    output logic        core_en,
    output logic        halted,
    output logic        step_done,
    output logic        bp_hit,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        pend_halt_q, pend_halt_d;
    logic        skip_bp_q, skip_bp_d;
    logic        bp_hit_q, bp_hit_d;
    logic        step_done_q, step_done_d;
    logic [15:0] count_q, count_d;

    logic        boundary;
    logic        bp_match;
    logic        stop_req;
    logic        en;

    assign boundary = ~phase;

`ifdef EXEC_CTRL_BP_EN
    assign bp_match = bp_valid & (pc == bp_addr) & ~skip_bp_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_valid, bp_addr};
    assign bp_match  = 1'b0;
`endif

    // A stop only takes effect on a fetch cycle, so the fetch itself is suppressed.
    assign stop_req = boundary & (halt_req | pend_halt_q | bp_match);

    always_comb begin
        state_d     = state_q;
        pend_halt_d = pend_halt_q;
        skip_bp_d   = skip_bp_q;
        bp_hit_d    = bp_hit_q;
        step_done_d = 1'b0;
        en          = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (step_req) begin
                    state_d  = ST_STEP;
                    bp_hit_d = 1'b0;
                end else if (run_req) begin
                    state_d   = ST_RUN;
                    skip_bp_d = 1'b1;
                    bp_hit_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop_req) begin
                    state_d     = ST_HALT;
                    pend_halt_d = 1'b0;
                    if (bp_match) begin
                        bp_hit_d = 1'b1;
                    end
                end else begin
                    en        = 1'b1;
                    skip_bp_d = 1'b0;
                    if (halt_req & phase) begin
                        pend_halt_d = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                en = 1'b1;
                if (phase) begin
                    state_d     = ST_HALT;
                    step_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign core_en = en & ~reset;

    // Saturating count of enabled cycles; clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (cnt_clr) begin
            count_d = 16'h0000;
        end else if (core_en && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HALT;
            pend_halt_q <= 1'b0;
            skip_bp_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
            step_done_q <= 1'b0;
            count_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            pend_halt_q <= pend_halt_d;
            skip_bp_q   <= skip_bp_d;
            bp_hit_q    <= bp_hit_d;
            step_done_q <= step_done_d;
            count_q     <= count_d;
        end
    end

    assign halted      = (state_q == ST_HALT);
    assign step_done   = step_done_q;
    assign cycle_count = count_q;

`ifdef EXEC_CTRL_BP_EN
    assign bp_hit = bp_hit_q;
`else
    assign bp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed and randomized checks of exec_ctrl against a behavioural model,
// with the bench standing in for the core (phase/pc advance only while core_en is high).
module tb_exec_ctrl;

    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
`ifdef EXEC_CTRL_BP_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        phase = 1'b0;
    logic [11:0] pc = 12'h000;
    logic [11:0] bp_addr = 12'h000;
    logic        bp_valid = 1'b0;
    logic        core_en;
    logic        halted;
    logic        step_done;
    logic        bp_hit;
    logic [15:0] cycle_count;

    int nCompared = 0;
    int nMismatched = 0;

    logic [11:0] corePc = 12'h000;
    logic        corePhase = 1'b0;

    int mMode = M_HALT;
    bit mPend = 1'b0;
    bit mSkip = 1'b0;
    bit mBpHit = 1'b0;
    bit mStepDone = 1'b0;
    int mCount = 0;

    always #5 clk = ~clk;

    exec_ctrl dut (
        .clk(clk),
        .reset(reset),
        .run_req(run_req),
        .halt_req(halt_req),
        .step_req(step_req),
        .cnt_clr(cnt_clr),
        .phase(phase),
        .pc(pc),
        .bp_addr(bp_addr),
        .bp_valid(bp_valid),
        .core_en(core_en),
        .halted(halted),
        .step_done(step_done),
        .bp_hit(bp_hit),
        .cycle_count(cycle_count)
    );

    function automatic bit bpMatchNow();
        return BP_EN && bp_valid && (pc == bp_addr) && !mSkip;
    endfunction

    function automatic bit stopNow();
        return (phase == 1'b0) && (halt_req || mPend || bpMatchNow());
    endfunction

    function automatic bit modelEn();
        if (reset) return 1'b0;
        if (mMode == M_RUN) return !stopNow();
        return (mMode == M_STEP);
    endfunction

    // One clock: advance the reference model and the core stand-in, then drop all pulses.
    task automatic tick();
        bit enDut;
        bit enRef;
        bit rstNow;
        bit stopping;
        bit matching;
        enDut  = core_en;
        enRef  = modelEn();
        rstNow = reset;
        if (rstNow) begin
            mMode = M_HALT; mPend = 0; mSkip = 0; mBpHit = 0; mStepDone = 0; mCount = 0;
        end else begin
            mStepDone = (mMode == M_STEP) && phase;
            if (cnt_clr) mCount = 0;
            else if (enRef && mCount < 65535) mCount = mCount + 1;
            case (mMode)
                M_HALT: begin
                    if (step_req) begin mMode = M_STEP; mBpHit = 0; end
                    else if (run_req) begin mMode = M_RUN; mSkip = 1; mBpHit = 0; end
                end
                M_RUN: begin
                    stopping = stopNow();
                    matching = bpMatchNow();
                    if (stopping) begin
                        if (matching) mBpHit = 1;
                        mPend = 0;
                        mMode = M_HALT;
                    end else begin
                        mSkip = 0;
                        if (halt_req && phase) mPend = 1;
                    end
                end
                default: begin
                    if (phase) mMode = M_HALT;
                end
            endcase
        end
        @(posedge clk);
        if (enDut) begin
            if (corePhase) corePc = corePc + 12'd1;
            corePhase = ~corePhase;
        end
        if (rstNow) corePhase = 1'b0;
        @(negedge clk);
        phase = corePhase;
        pc = corePc;
        run_req = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        nCompared++; if (core_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_core_en got %b want 0", core_en); end
        nCompared++; if (halted !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_halted got %b want 1", halted); end
        nCompared++; if (step_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_step_done got %b want 0", step_done); end
        nCompared++; if (bp_hit !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_bp_hit got %b want 0", bp_hit); end
        nCompared++; if (cycle_count !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_count got %h want 0000", cycle_count); end
    endtask

    task automatic test_run();
        run_req = 1'b1;
        #1;
        nCompared++; if (core_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL run_req_cycle_en got %b want 0", core_en); end
        tick();
        #1;
        nCompared++; if (core_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL run_first_en got %b want 1", core_en); end
        nCompared++; if (halted !== 1'b0) begin nMismatched++; $display("[TB] FAIL run_halted got %b want 0", halted); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            #1;
            nCompared++; if (cycle_count !== 16'(i)) begin nMismatched++; $display("[TB] FAIL run_count got %0d want %0d", cycle_count, i); end
        end
    endtask

    task automatic test_halt_phase1();
        if (phase == 1'b0) tick();
        halt_req = 1'b1;
        #1;
        nCompared++; if (core_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL halt_p1_en got %b want 1", core_en); end
        tick();
        #1;
        nCompared++; if (core_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL halt_boundary_en got %b want 0", core_en); end
        tick();
        #1;
        nCompared++; if (halted !== 1'b1) begin nMismatched++; $display("[TB] FAIL halt_halted got %b want 1", halted); end
        nCompared++; if (core_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL halt_hold_en got %b want 0", core_en); end
    endtask

    task automatic test_step();
        logic [11:0] pc0;
        logic [15:0] cntWant;
        pc0 = corePc;
        cntWant = 16'(mCount + 2);
        step_req = 1'b1;
        #1;
        nCompared++; if (core_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL step_req_en got %b want 0", core_en); end
        tick();
        #1;
        nCompared++; if (core_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL step_fetch_en got %b want 1", core_en); end
        tick();
        #1;
        nCompared++; if (core_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL step_exec_en got %b want 1", core_en); end
        tick();
        #1;
        nCompared++; if (core_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL step_end_en got %b want 0", core_en); end
        nCompared++; if (step_done !== 1'b1) begin nMismatched++; $display("[TB] FAIL step_done_pulse got %b want 1", step_done); end
        nCompared++; if (halted !== 1'b1) begin nMismatched++; $display("[TB] FAIL step_halted got %b want 1", halted); end
        nCompared++; if (pc !== pc0 + 12'd1) begin nMismatched++; $display("[TB] FAIL step_pc got %h want %h", pc, pc0 + 12'd1); end
        nCompared++; if (cycle_count !== cntWant) begin nMismatched++; $display("[TB] FAIL step_count got %h want %h", cycle_count, cntWant); end
        tick();
        #1;
        nCompared++; if (step_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL step_done_width got %b want 0", step_done); end
    endtask

    task automatic test_breakpoint();
        bit seen;
        seen = 1'b0;
        corePc = 12'h000;
        corePhase = 1'b0;
        pc = 12'h000;
        phase = 1'b0;
        bp_valid = 1'b1;
        bp_addr = 12'h005;
        run_req = 1'b1;
        tick();
        for (int k = 0; k < 40; k++) begin
            #1;
            if (halted) begin seen = 1'b1; break; end
            tick();
        end
`ifdef EXEC_CTRL_BP_EN
        nCompared++; if (seen !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_stop got %b want 1 (timeout)", seen); end
        nCompared++; if (pc !== 12'h005) begin nMismatched++; $display("[TB] FAIL bp_pc got %h want 005", pc); end
        nCompared++; if (bp_hit !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_hit_set got %b want 1", bp_hit); end
        run_req = 1'b1;
        tick();
        #1;
        nCompared++; if (core_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_resume_en got %b want 1", core_en); end
        nCompared++; if (bp_hit !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_hit_clear got %b want 0", bp_hit); end
        for (int k = 0; k < 6; k++) begin
            tick();
            #1;
            nCompared++; if (halted !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_restop got %b want 0", halted); end
        end
        nCompared++; if (pc !== 12'h008) begin nMismatched++; $display("[TB] FAIL bp_resume_pc got %h want 008", pc); end
`else
        nCompared++; if (seen !== 1'b0) begin nMismatched++; $display("[TB] FAIL nobp_stop got %b want 0", seen); end
        nCompared++; if (bp_hit !== 1'b0) begin nMismatched++; $display("[TB] FAIL nobp_hit got %b want 0", bp_hit); end
`endif
        bp_valid = 1'b0;
        halt_req = 1'b1;
        tick();
        for (int k = 0; k < 4 && !halted; k++) tick();
        #1;
        nCompared++; if (halted !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_final_halt got %b want 1", halted); end
    endtask

    task automatic test_reset_mid_step();
        step_req = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        nCompared++; if (core_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL rststep_en_during got %b want 0", core_en); end
        tick();
        reset = 1'b0;
        #1;
        nCompared++; if (halted !== 1'b1) begin nMismatched++; $display("[TB] FAIL rststep_halted got %b want 1", halted); end
        nCompared++; if (step_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL rststep_done got %b want 0", step_done); end
        nCompared++; if (core_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL rststep_en got %b want 0", core_en); end
        nCompared++; if (cycle_count !== 16'h0000) begin nMismatched++; $display("[TB] FAIL rststep_count got %h want 0000", cycle_count); end
        tick();
        #1;
        nCompared++; if (step_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL rststep_late_done got %b want 0", step_done); end
    endtask

    task automatic test_saturate();
        cnt_clr = 1'b1;
        tick();
        run_req = 1'b1;
        tick();
        for (int k = 0; k < 65534; k++) tick();
        #1;
        nCompared++; if (cycle_count !== 16'hFFFE) begin nMismatched++; $display("[TB] FAIL sat_fffe got %h want fffe", cycle_count); end
        tick();
        #1;
        nCompared++; if (cycle_count !== 16'hFFFF) begin nMismatched++; $display("[TB] FAIL sat_ffff got %h want ffff", cycle_count); end
        tick();
        tick();
        tick();
        #1;
        nCompared++; if (cycle_count !== 16'hFFFF) begin nMismatched++; $display("[TB] FAIL sat_hold got %h want ffff", cycle_count); end
        cnt_clr = 1'b1;
        tick();
        #1;
        nCompared++; if (cycle_count !== 16'h0000) begin nMismatched++; $display("[TB] FAIL sat_clear got %h want 0000", cycle_count); end
        halt_req = 1'b1;
        tick();
        for (int k = 0; k < 4 && !halted; k++) tick();
        #1;
        nCompared++; if (halted !== 1'b1) begin nMismatched++; $display("[TB] FAIL sat_final_halt got %b want 1", halted); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            run_req  = ($urandom_range(0, 7) == 0);
            halt_req = ($urandom_range(0, 9) == 0);
            step_req = ($urandom_range(0, 9) == 0);
            cnt_clr  = ($urandom_range(0, 63) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            if ((n % 20) == 0) begin
                bp_valid = 1'($urandom_range(0, 1));
                bp_addr  = corePc + 12'($urandom_range(0, 6));
            end
            #1;
            nCompared++; if (core_en !== modelEn()) begin nMismatched++; $display("[TB] FAIL rnd_core_en n=%0d got %b want %b", n, core_en, modelEn()); end
            nCompared++; if (halted !== (mMode == M_HALT)) begin nMismatched++; $display("[TB] FAIL rnd_halted n=%0d got %b want %b", n, halted, (mMode == M_HALT)); end
            nCompared++; if (step_done !== mStepDone) begin nMismatched++; $display("[TB] FAIL rnd_step_done n=%0d got %b want %b", n, step_done, mStepDone); end
            nCompared++; if (bp_hit !== mBpHit) begin nMismatched++; $display("[TB] FAIL rnd_bp_hit n=%0d got %b want %b", n, bp_hit, mBpHit); end
            nCompared++; if (cycle_count !== mCount[15:0]) begin nMismatched++; $display("[TB] FAIL rnd_count n=%0d got %h want %h", n, cycle_count, mCount[15:0]); end
            tick();
            reset = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_run();
        test_halt_phase1();
        test_step();
        test_breakpoint();
        test_reset_mid_step();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
